// File: rtl/pow2_lut_div_if.sv
// rtl/pow2_lut_div_if.sv - operand/result handshake bundle for pow2_lut_div
interface pow2_lut_div_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic              div_by_zero;
  logic              overflow;
  logic              busy;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow, busy
  );
endinterface

// File: rtl/pow2_lut_div.sv
// rtl/pow2_lut_div.sv - iterative unsigned divider using a power-of-two weight table
// Restoring division over ITERS table weights; quotients of 2^ITERS or more saturate and flag overflow.
module pow2_lut_div #(
  parameter int DATA_W = 16,
  parameter int ITERS  = 7
) (
  input logic           clk,
  input logic           rst,
  pow2_lut_div_if.slave io
);
  localparam int EXT_W = DATA_W + ITERS;
  localparam int IDX_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ITERS - 1);
  localparam logic [DATA_W-1:0] Q_SAT    = DATA_W'((1 << ITERS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] r_q, r_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] q_q, q_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic              ovf_q, ovf_d;

  logic [ITERS-1:0] weight_tbl [ITERS];

  for (genvar gi = 0; gi < ITERS; gi++) begin : g_weight
    assign weight_tbl[gi] = ITERS'(1) << (ITERS - 1 - gi);
  end

  logic [IDX_W-1:0]  shamt;
  logic [EXT_W-1:0]  r_ext;
  logic [EXT_W-1:0]  dw_ext;
  logic [DATA_W-1:0] weight;
  logic              take;
  logic [DATA_W-1:0] r_step;
  logic [DATA_W-1:0] q_step;

  // D*W is a shift by log2(W); the compare is done wide so large D*W never wraps.
  always_comb begin
    shamt  = LAST_IDX - idx_q;
    r_ext  = {{ITERS{1'b0}}, r_q};
    dw_ext = {{ITERS{1'b0}}, d_q} << shamt;
    weight = {{(DATA_W - ITERS){1'b0}}, weight_tbl[idx_q]};
    take   = (r_ext >= dw_ext);
    r_step = take ? (r_q - dw_ext[DATA_W-1:0]) : r_q;
    q_step = take ? (q_q + weight) : q_q;
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    d_d     = d_q;
    q_d     = q_q;
    idx_d   = idx_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          q_d     = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          d_d     = io.divisor;
          state_d = RUN;
          if (io.divisor == '0) begin
            // Zero divisor: result is loaded now, RUN is a single pass-through cycle.
            dbz_d = 1'b1;
            quo_d = '1;
            rem_d = io.dividend;
            r_d   = '0;
          end else begin
            dbz_d = 1'b0;
            r_d   = io.dividend;
          end
        end
      end
      RUN: begin
        if (dbz_q) begin
          state_d = DONE;
        end else begin
          r_d   = r_step;
          q_d   = q_step;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            idx_d   = '0;
            ovf_d   = (r_step >= d_q);
            quo_d   = (r_step >= d_q) ? Q_SAT : q_step;
            rem_d   = r_step;
          end
        end
      end
      DONE: begin
        if (io.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      d_q     <= '0;
      q_q     <= '0;
      idx_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      q_q     <= q_d;
      idx_q   <= idx_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.in_ready    = (state_q == IDLE);
  assign io.out_valid   = (state_q == DONE);
  assign io.busy        = (state_q != IDLE);
  assign io.quotient    = quo_q;
  assign io.remainder   = rem_q;
  assign io.div_by_zero = dbz_q;
  assign io.overflow    = ovf_q;
endmodule

// File: tb/tb_pow2_lut_div.sv
// tb/tb_pow2_lut_div.sv - directed bench for pow2_lut_div (DATA_W=16, ITERS=7)
module tb_pow2_lut_div;
  localparam int DATA_W = 16;
  localparam int ITERS  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  pow2_lut_div_if #(.DATA_W(DATA_W)) bus ();

  pow2_lut_div #(.DATA_W(DATA_W), .ITERS(ITERS)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eq, input logic [15:0] er,
                        input logic edbz, input logic eovf, input int elat, input int hold);
    int w;
    int lat;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    check({tag, " in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    step();
    bus.in_valid = 1'b0;
    bus.dividend = ~a;
    bus.divisor  = 16'h0000;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " quotient"}, bus.quotient, eq);
    check({tag, " remainder"}, bus.remainder, er);
    check({tag, " div_by_zero"}, bus.div_by_zero, edbz);
    check({tag, " overflow"}, bus.overflow, eovf);
    check({tag, " busy"}, bus.busy, 1);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = (h % 2 == 0);
      bus.dividend = 16'h1234;
      bus.divisor  = 16'h0003;
      step();
      check({tag, " hold quotient"}, bus.quotient, eq);
      check({tag, " hold remainder"}, bus.remainder, er);
      check({tag, " hold out_valid"}, bus.out_valid, 1);
      check({tag, " hold in_ready"}, bus.in_ready, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " post out_valid"}, bus.out_valid, 0);
    check({tag, " post in_ready"}, bus.in_ready, 1);
    if (hold > 0) begin
      step();
      check({tag, " stays idle"}, bus.busy, 0);
    end
  endtask

  initial begin
    int w;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;

    rst = 1'b1;
    step();
    step();
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst busy", bus.busy, 0);
    check("rst quotient", bus.quotient, 0);
    check("rst remainder", bus.remainder, 0);
    check("rst div_by_zero", bus.div_by_zero, 0);
    check("rst overflow", bus.overflow, 0);
    rst = 1'b0;
    step();

    do_div("100/7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 1'b0, 7, 0);
    do_div("127/1", 16'd127, 16'd1, 16'd127, 16'd0, 1'b0, 1'b0, 7, 0);
    do_div("200/1", 16'd200, 16'd1, 16'd127, 16'd73, 1'b0, 1'b1, 7, 0);
    do_div("55/0", 16'd55, 16'd0, 16'hFFFF, 16'd55, 1'b1, 1'b0, 1, 0);
    do_div("1000/9 hold", 16'd1000, 16'd9, 16'd111, 16'd1, 1'b0, 1'b0, 7, 5);

    // Abort a division at idx=3
    bus.in_valid = 1'b1;
    bus.dividend = 16'd50;
    bus.divisor  = 16'd5;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    step();
    check("abort busy before rst", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort in_ready", bus.in_ready, 1);
    check("abort out_valid", bus.out_valid, 0);
    check("abort busy", bus.busy, 0);
    check("abort quotient", bus.quotient, 0);
    check("abort remainder", bus.remainder, 0);
    check("abort div_by_zero", bus.div_by_zero, 0);
    check("abort overflow", bus.overflow, 0);
    step();
    check("abort stays idle", bus.busy, 0);

    // Reset coincident with an accept
    bus.in_valid = 1'b1;
    bus.dividend = 16'd9;
    bus.divisor  = 16'd0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    check("rst+accept busy", bus.busy, 0);
    step();
    check("rst+accept still idle", bus.busy, 0);
    check("rst+accept out_valid", bus.out_valid, 0);

    do_div("9/3", 16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0, 7, 0);

    // Reset coincident with the output handshake
    bus.in_valid = 1'b1;
    bus.dividend = 16'd100;
    bus.divisor  = 16'd7;
    step();
    bus.in_valid = 1'b0;
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 40) begin
      step();
      w++;
    end
    check("rst+hs reached done", bus.out_valid, 1);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.out_ready = 1'b0;
    check("rst+hs quotient", bus.quotient, 0);
    check("rst+hs remainder", bus.remainder, 0);
    check("rst+hs out_valid", bus.out_valid, 0);
    check("rst+hs in_ready", bus.in_ready, 1);

    // Back-to-back directed operands
    do_div("65535/600", 16'd65535, 16'd600, 16'd109, 16'd135, 1'b0, 1'b0, 7, 0);
    do_div("0/5", 16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 1'b0, 7, 0);
    do_div("5/9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 1'b0, 7, 0);
    do_div("12345/100", 16'd12345, 16'd100, 16'd123, 16'd45, 1'b0, 1'b0, 7, 0);
    do_div("40000/320", 16'd40000, 16'd320, 16'd125, 16'd0, 1'b0, 1'b0, 7, 0);
    do_div("60000/1025", 16'd60000, 16'd1025, 16'd58, 16'd550, 1'b0, 1'b0, 7, 0);
    do_div("65535/65535", 16'd65535, 16'd65535, 16'd1, 16'd0, 1'b0, 1'b0, 7, 0);
    do_div("1/1", 16'd1, 16'd1, 16'd1, 16'd0, 1'b0, 1'b0, 7, 0);
    do_div("128/1", 16'd128, 16'd1, 16'd127, 16'd1, 1'b0, 1'b1, 7, 0);
    do_div("0/0", 16'd0, 16'd0, 16'hFFFF, 16'd0, 1'b1, 1'b0, 1, 0);
    do_div("77/11", 16'd77, 16'd11, 16'd7, 16'd0, 1'b0, 1'b0, 7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
